fft16_seq_ctrl: RTL and testbench

//  Sequencer for a 16-point radix-2 DIT complex FFT built on one shared butterfly_2 instance.
//  - Loads one 16-sample frame over a valid/ready stream into an internal in-place buffer.
//  - Runs 4 stages x 8 butterflies through the single butterfly and drives the twiddle lookup.
//  - Streams results out in natural order.
//  - Sits between the sample source and the spectrum consumer; the twiddle ROM is external.

---
 rtl/fft16_seq_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_fft16_seq_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft16_seq_ctrl.sv
// fft16_seq_ctrl: 16-point radix-2 DIT complex FFT sequencer around one shared butterfly_2; FFT_SCALE_EN halves every stage (output = DFT/16).
// Latency: last input beat to first out_valid is 33 cycles. Backpressure: in_ready only in LOAD, out_ready stalls DRAIN with data held.

// butterfly_2: y0 = x0 + x1*tw, y1 = x0 - x1*tw with the product rounded to Q fractional bits.
// Latency: combinational. Backpressure: none.
// Sums are returned one bit wider so the caller chooses wrap or halve.
module butterfly_2 #(
  parameter int N = 16,
  parameter int Q = 8
) (
  input  logic signed [N-1:0] x0_r,
  input  logic signed [N-1:0] x0_i,
  input  logic signed [N-1:0] x1_r,
  input  logic signed [N-1:0] x1_i,
  input  logic signed [N-1:0] tw_r,
  input  logic signed [N-1:0] tw_i,
  output logic signed [N:0]   y0_r,
  output logic signed [N:0]   y0_i,
  output logic signed [N:0]   y1_r,
  output logic signed [N:0]   y1_i
);
  localparam int RND = 1 << (Q - 1);

  logic signed [2*N-1:0] m_rr, m_ii, m_ri, m_ir;
  logic signed [2*N:0]   p_r, p_i;
  logic signed [N-1:0]   t_r, t_i;

  always_comb begin
    m_rr = (2*N)'(x1_r) * (2*N)'(tw_r);
    m_ii = (2*N)'(x1_i) * (2*N)'(tw_i);
    m_ri = (2*N)'(x1_r) * (2*N)'(tw_i);
    m_ir = (2*N)'(x1_i) * (2*N)'(tw_r);
    p_r  = (2*N+1)'(m_rr) - (2*N+1)'(m_ii) + (2*N+1)'(RND);
    p_i  = (2*N+1)'(m_ri) + (2*N+1)'(m_ir) + (2*N+1)'(RND);
    // round half up to Q fractional bits, then wrap to the sample width
    t_r  = N'(p_r >>> Q);
    t_i  = N'(p_i >>> Q);
    y0_r = (N+1)'(x0_r) + (N+1)'(t_r);
    y0_i = (N+1)'(x0_i) + (N+1)'(t_i);
    y1_r = (N+1)'(x0_r) - (N+1)'(t_r);
    y1_i = (N+1)'(x0_i) - (N+1)'(t_i);
  end
endmodule

module fft16_seq_ctrl #(
  parameter int N = 16,
  parameter int Q = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [N-1:0] in_r,
  input  logic signed [N-1:0] in_i,
  output logic [2:0]          tw_idx,
  input  logic signed [N-1:0] tw_r,
  input  logic signed [N-1:0] tw_i,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [N-1:0] out_r,
  output logic signed [N-1:0] out_i,
  output logic                out_last,
  output logic                busy
);
  typedef enum logic [1:0] {ST_LOAD, ST_CALC, ST_DRAIN} state_t;

  state_t              state_q, state_d;
  logic [4:0]          cnt_q, cnt_d;
  logic signed [N-1:0] mem_r_q [16];
  logic signed [N-1:0] mem_r_d [16];
  logic signed [N-1:0] mem_i_q [16];
  logic signed [N-1:0] mem_i_d [16];

  logic [1:0]          stage;
  logic [2:0]          bfly;
  logic [3:0]          addr_a, addr_c;
  logic [2:0]          tw_k;
  logic signed [N:0]   y0_r, y0_i, y1_r, y1_i;

  function automatic logic [3:0] bitrev4(input logic [3:0] n);
    return {n[0], n[1], n[2], n[3]};
  endfunction

  function automatic logic signed [N-1:0] fit(input logic signed [N:0] y);
`ifdef FFT_SCALE_EN
    logic signed [N:0] s;
    s = y + (N+1)'(1);
    return N'(s >>> 1);
`else
    return N'(y);
`endif
  endfunction

  // cnt_q = {stage, butterfly}; pairs are span = 1<<stage apart
  always_comb begin
    stage  = cnt_q[4:3];
    bfly   = cnt_q[2:0];
    addr_a = '0;
    addr_c = '0;
    tw_k   = '0;
    case (stage)
      2'd0: begin
        addr_a = {bfly, 1'b0};
        addr_c = {bfly, 1'b1};
        tw_k   = 3'd0;
      end
      2'd1: begin
        addr_a = {bfly[2:1], 1'b0, bfly[0]};
        addr_c = {bfly[2:1], 1'b1, bfly[0]};
        tw_k   = {bfly[0], 2'b00};
      end
      2'd2: begin
        addr_a = {bfly[2], 1'b0, bfly[1:0]};
        addr_c = {bfly[2], 1'b1, bfly[1:0]};
        tw_k   = {bfly[1:0], 1'b0};
      end
      default: begin
        addr_a = {1'b0, bfly};
        addr_c = {1'b1, bfly};
        tw_k   = bfly;
      end
    endcase
  end

  butterfly_2 #(.N(N), .Q(Q)) u_bfly (
    .x0_r (mem_r_q[addr_a]),
    .x0_i (mem_i_q[addr_a]),
    .x1_r (mem_r_q[addr_c]),
    .x1_i (mem_i_q[addr_c]),
    .tw_r (tw_r),
    .tw_i (tw_i),
    .y0_r (y0_r),
    .y0_i (y0_i),
    .y1_r (y1_r),
    .y1_i (y1_i)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_r_d   = mem_r_q;
    mem_i_d   = mem_i_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b0;
    tw_idx    = 3'd0;
    out_r     = mem_r_q[cnt_q[3:0]];
    out_i     = mem_i_q[cnt_q[3:0]];
    case (state_q)
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          mem_r_d[bitrev4(cnt_q[3:0])] = in_r;
          mem_i_d[bitrev4(cnt_q[3:0])] = in_i;
          if (cnt_q == 5'd15) begin
            cnt_d   = 5'd0;
            state_d = ST_CALC;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      ST_CALC: begin
        busy            = 1'b1;
        tw_idx          = tw_k;
        mem_r_d[addr_a] = fit(y0_r);
        mem_i_d[addr_a] = fit(y0_i);
        mem_r_d[addr_c] = fit(y1_r);
        mem_i_d[addr_c] = fit(y1_i);
        if (cnt_q == 5'd31) begin
          cnt_d   = 5'd0;
          state_d = ST_DRAIN;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      ST_DRAIN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_last  = (cnt_q[3:0] == 4'd15);
        if (out_ready) begin
          if (cnt_q[3:0] == 4'd15) begin
            cnt_d   = 5'd0;
            state_d = ST_LOAD;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      default: begin
        state_d = ST_LOAD;
        cnt_d   = 5'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LOAD;
      cnt_q   <= '0;
      for (int k = 0; k < 16; k++) begin
        mem_r_q[k] <= '0;
        mem_i_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mem_r_q <= mem_r_d;
      mem_i_q <= mem_i_d;
    end
  end
endmodule

// File: tb/tb_fft16_seq_ctrl.sv
// Bench for fft16_seq_ctrl (default build): directed frames, expected bins queued at issue time,
// a negedge monitor pops and compares every output handshake.
module tb_fft16_seq_ctrl;
  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [15:0] in_r = '0;
  logic signed [15:0] in_i = '0;
  logic [2:0]         tw_idx;
  logic signed [15:0] tw_r, tw_i;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic signed [15:0] out_r, out_i;
  logic               out_last;
  logic               busy;

  always #5 clk = ~clk;

  fft16_seq_ctrl #(.N(16), .Q(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_r      (in_r),
    .in_i      (in_i),
    .tw_idx    (tw_idx),
    .tw_r      (tw_r),
    .tw_i      (tw_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .out_i     (out_i),
    .out_last  (out_last),
    .busy      (busy)
  );

  // External Q8 twiddle table: W16^k = cos - j*sin
  always_comb begin
    tw_r = 16'sd256;
    tw_i = 16'sd0;
    case (tw_idx)
      3'd1: begin tw_r = 16'sd237;  tw_i = -16'sd98;  end
      3'd2: begin tw_r = 16'sd181;  tw_i = -16'sd181; end
      3'd3: begin tw_r = 16'sd98;   tw_i = -16'sd237; end
      3'd4: begin tw_r = 16'sd0;    tw_i = -16'sd256; end
      3'd5: begin tw_r = -16'sd98;  tw_i = -16'sd237; end
      3'd6: begin tw_r = -16'sd181; tw_i = -16'sd181; end
      3'd7: begin tw_r = -16'sd237; tw_i = -16'sd98;  end
      default: begin tw_r = 16'sd256; tw_i = 16'sd0; end
    endcase
  end

  typedef struct {
    int r;
    int i;
    int tol;
    int bin;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   frm_r[16], frm_i[16];
  int   ex_r[16], ex_i[16];

  task automatic chk(input string name, input int act, input int exp, input int tol);
    checks++;
    if (act < exp - tol || act > exp + tol) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d tol=%0d", name, act, exp, tol);
    end
  endtask

  // Monitor: one pop per output handshake; data must hold across a stall.
  logic stall_q = 1'b0;
  int   hold_r = 0;
  int   hold_i = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q && out_valid) begin
        chk("hold_re", int'(out_r), hold_r, 0);
        chk("hold_im", int'(out_i), hold_i, 0);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", int'(out_valid), 0, 0);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("bin%0d_re", e.bin), int'(out_r), e.r, e.tol);
          chk($sformatf("bin%0d_im", e.bin), int'(out_i), e.i, e.tol);
          chk($sformatf("bin%0d_last", e.bin), int'(out_last), (e.bin == 15) ? 1 : 0, 0);
        end
      end
      stall_q = out_valid && !out_ready;
      hold_r  = int'(out_r);
      hold_i  = int'(out_i);
    end
  end

  task automatic push_exp(input int tol);
    exp_t e;
    for (int k = 0; k < 16; k++) begin
      e.r = ex_r[k];
      e.i = ex_i[k];
      e.tol = tol;
      e.bin = k;
      exp_q.push_back(e);
    end
  endtask

  task automatic set_impulse();
    for (int k = 0; k < 16; k++) begin
      frm_r[k] = 0;   frm_i[k] = 0;
      ex_r[k]  = 256; ex_i[k]  = 0;
    end
    frm_r[0] = 256;
  endtask

  task automatic set_dc();
    for (int k = 0; k < 16; k++) begin
      frm_r[k] = 16; frm_i[k] = 0;
      ex_r[k]  = 0;  ex_i[k]  = 0;
    end
    ex_r[0] = 256;
  endtask

  // Bin-1 tone from the rounded table. The +0.18% gain of the rounded (237,98) points
  // in both samples and W^1 pushes bin1 to ~(4103,1) and leaks ~(-8,-1) into bin9.
  task automatic set_tone();
    frm_r = '{256, 237, 181, 98, 0, -98, -181, -237, -256, -237, -181, -98, 0, 98, 181, 237};
    frm_i = '{0, 98, 181, 237, 256, 237, 181, 98, 0, -98, -181, -237, -256, -237, -181, -98};
    for (int k = 0; k < 16; k++) begin
      ex_r[k] = 0; ex_i[k] = 0;
    end
    ex_r[1] = 4103; ex_i[1] = 1;
    ex_r[9] = -8;   ex_i[9] = -1;
  endtask

  // Returns at #1 after the edge that accepted beat 15.
  task automatic send_frame(input bit gap);
    int  n = 0;
    int  cyc = 0;
    bit  hs;
    while (n < 16 && cyc < 400) begin
      in_valid = gap ? ~cyc[0] : 1'b1;
      in_r = 16'(frm_r[n]);
      in_i = 16'(frm_i[n]);
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (hs) n++;
      cyc++;
    end
    in_valid = 1'b0;
    in_r = '0;
    in_i = '0;
    chk("load_beats", n, 16, 0);
  endtask

  task automatic wait_done(input string name);
    int cyc = 0;
    while ((exp_q.size() != 0 || !in_ready) && cyc < 300) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({name, "_pending_bins"}, exp_q.size(), 0, 0);
    chk({name, "_back_in_load"}, int'(in_ready), 1, 0);
  endtask

  initial begin
    int         g;
    int         c;
    int         stalls;
    int         lat;
    int         bc;
    bit         done;
    logic [3:0] pat;

    #1;
    chk("rst_in_ready", int'(in_ready), 1, 0);
    chk("rst_out_valid", int'(out_valid), 0, 0);
    chk("rst_out_last", int'(out_last), 0, 0);
    chk("rst_busy", int'(busy), 0, 0);
    chk("rst_tw_idx", int'(tw_idx), 0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("load_in_ready", int'(in_ready), 1, 0);
    chk("load_tw_idx", int'(tw_idx), 0, 0);

    set_impulse();
    push_exp(0);
    send_frame(1'b0);
    chk("calc_in_ready", int'(in_ready), 0, 0);
    chk("calc_busy", int'(busy), 1, 0);
    wait_done("impulse");

    set_dc();
    push_exp(1);
    send_frame(1'b0);
    wait_done("dc");

    set_tone();
    push_exp(4);
    send_frame(1'b0);
    wait_done("tone");

    // Backpressure: out_ready 1,0,0,1 from the first DRAIN cycle; bin15 sits stalled twice.
    set_tone();
    push_exp(4);
    out_ready = 1'b0;
    send_frame(1'b0);
    g = 0;
    while (!out_valid && g < 100) begin
      @(posedge clk);
      #1;
      g++;
    end
    pat = 4'b1001;
    c = 0;
    stalls = 0;
    done = 1'b0;
    while (!done && c < 200) begin
      out_ready = pat[c % 4];
      @(negedge clk);
      if (out_valid && out_last && !out_ready) begin
        stalls++;
        chk("bp_in_ready_stalled", int'(in_ready), 0, 0);
      end
      done = out_valid && out_last && out_ready;
      @(posedge clk);
      #1;
      c++;
    end
    out_ready = 1'b1;
    chk("bp_bin15_stalls", stalls, 2, 0);
    chk("bp_drain_cycles", c, 32, 0);
    chk("bp_in_ready_after", int'(in_ready), 1, 0);
    chk("bp_out_valid_after", int'(out_valid), 0, 0);
    wait_done("backpressure");

    // Gapped input, then latency and busy window measured from the cycle after beat 15.
    set_impulse();
    push_exp(0);
    send_frame(1'b1);
    chk("gap_calc_busy", int'(busy), 1, 0);
    chk("gap_calc_in_ready", int'(in_ready), 0, 0);
    lat = -1;
    bc = 0;
    g = 1;
    while (busy && g < 200) begin
      if (out_valid && lat < 0) lat = g;
      bc++;
      @(posedge clk);
      #1;
      g++;
    end
    chk("gap_latency", lat, 33, 0);
    chk("gap_busy_cycles", bc, 48, 0);
    wait_done("gapped");

    // Abort during CALC cycle 10: nothing queued, so any output is flagged by the monitor.
    set_dc();
    send_frame(1'b0);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", int'(out_valid), 0, 0);
    chk("abort_in_ready", int'(in_ready), 1, 0);
    chk("abort_busy", int'(busy), 0, 0);
    chk("abort_tw_idx", int'(tw_idx), 0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    set_dc();
    push_exp(1);
    send_frame(1'b0);
    wait_done("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
endmodule
